// File: rtl/bn_pkg.sv
// Shared BatchNorm definitions: sequencer state encoding, saturation limits
// and the clamp helpers used by the BN lanes.
package bn_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int SUM_WIDTH  = 2 * DATA_WIDTH + 1;

    localparam logic signed [SUM_WIDTH-1:0] SAT_MAX = SUM_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [SUM_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } bn_state_e;

    function automatic logic is_sat(input logic signed [SUM_WIDTH-1:0] sum);
        return (sum > SAT_MAX) || (sum < SAT_MIN);
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] sat_clamp(input logic signed [SUM_WIDTH-1:0] sum);
        logic signed [DATA_WIDTH-1:0] res;
        if (sum > SAT_MAX) begin
            res = SAT_MAX[DATA_WIDTH-1:0];
        end else if (sum < SAT_MIN) begin
            res = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            res = sum[DATA_WIDTH-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/bn_stream_ctrl_if.sv
// Start/status, parameter-memory and stream handshake bundle of bn_stream_ctrl.
// master = the sequencer, slave = its surroundings.
interface bn_stream_ctrl_if #(
    parameter int AW = 4
);
    import bn_pkg::*;

    logic                         start;
    logic                         busy;
    logic                         done;
    logic                         param_rd;
    logic [AW-1:0]                param_addr;
    logic signed [DATA_WIDTH-1:0] param_weight;
    logic signed [DATA_WIDTH-1:0] param_bias;
    logic                         s_valid;
    logic                         s_ready;
    logic signed [DATA_WIDTH-1:0] s_data;
    logic                         m_valid;
    logic                         m_ready;
    logic signed [DATA_WIDTH-1:0] m_data;
    logic [AW-1:0]                m_chan;
    logic                         m_last;

    modport master (
        input  start, param_weight, param_bias, s_valid, s_data, m_ready,
        output busy, done, param_rd, param_addr, s_ready, m_valid, m_data, m_chan, m_last
    );

    modport slave (
        output start, param_weight, param_bias, s_valid, s_data, m_ready,
        input  busy, done, param_rd, param_addr, s_ready, m_valid, m_data, m_chan, m_last
    );

endinterface

// File: rtl/bn_mac_lane.sv
// Two-stage multiply / shift / bias-add / saturate lane. Both stages advance
// together on en and hold otherwise, so stage 2 is the output register.
module bn_mac_lane
    import bn_pkg::*;
#(
    parameter int FRAC_BITS = 4,
    parameter int AW        = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic signed [DATA_WIDTH-1:0] in_weight,
    input  logic signed [DATA_WIDTH-1:0] in_bias,
    input  logic [AW-1:0]                in_chan,
    input  logic                         in_last,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic [AW-1:0]                out_chan,
    output logic                         out_last,
    output logic                         out_sat
);
    localparam int MW = 2 * DATA_WIDTH;

    logic signed [MW-1:0]         prod_s;
    logic signed [SUM_WIDTH-1:0]  sum_s;
    logic                         v1_q, v1_d, last1_q, last1_d;
    logic signed [MW-1:0]         prod1_q, prod1_d;
    logic signed [DATA_WIDTH-1:0] bias1_q, bias1_d;
    logic [AW-1:0]                chan1_q, chan1_d;
    logic                         v2_q, v2_d, last2_q, last2_d, sat2_q, sat2_d;
    logic signed [DATA_WIDTH-1:0] data2_q, data2_d;
    logic [AW-1:0]                chan2_q, chan2_d;

    // Stage next values; bias rides along with the product so stage 2 needs no lookup
    always_comb begin
        prod_s  = MW'(in_data) * MW'(in_weight);
        sum_s   = SUM_WIDTH'(prod1_q >>> FRAC_BITS) + SUM_WIDTH'(bias1_q);
        v1_d    = v1_q;
        prod1_d = prod1_q;
        bias1_d = bias1_q;
        chan1_d = chan1_q;
        last1_d = last1_q;
        v2_d    = v2_q;
        data2_d = data2_q;
        chan2_d = chan2_q;
        last2_d = last2_q;
        sat2_d  = sat2_q;
        if (en) begin
            v1_d = in_valid;
            v2_d = v1_q;
            if (in_valid) begin
                prod1_d = prod_s;
                bias1_d = in_bias;
                chan1_d = in_chan;
                last1_d = in_last;
            end else begin
                prod1_d = prod1_q;
            end
            if (v1_q) begin
                data2_d = sat_clamp(sum_s);
                sat2_d  = is_sat(sum_s);
                chan2_d = chan1_q;
                last2_d = last1_q;
            end else begin
                data2_d = data2_q;
            end
        end else begin
            v1_d = v1_q;
        end
    end

    // Pipeline registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            prod1_q <= {MW{1'b0}};
            bias1_q <= {DATA_WIDTH{1'b0}};
            chan1_q <= {AW{1'b0}};
            last1_q <= 1'b0;
            v2_q    <= 1'b0;
            data2_q <= {DATA_WIDTH{1'b0}};
            chan2_q <= {AW{1'b0}};
            last2_q <= 1'b0;
            sat2_q  <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            prod1_q <= prod1_d;
            bias1_q <= bias1_d;
            chan1_q <= chan1_d;
            last1_q <= last1_d;
            v2_q    <= v2_d;
            data2_q <= data2_d;
            chan2_q <= chan2_d;
            last2_q <= last2_d;
            sat2_q  <= sat2_d;
        end
    end

    assign out_valid = v2_q;
    assign out_data  = data2_q;
    assign out_chan  = chan2_q;
    assign out_last  = last2_q;
    assign out_sat   = sat2_q;

endmodule

// File: rtl/bn_stream_ctrl.sv
// Fused-BatchNorm stream sequencer: loads per-channel weight/bias, then streams
// activations through bn_mac_lane. BN_SAT_COUNT_EN adds the sat_count output.
module bn_stream_ctrl
    import bn_pkg::*;
#(
    parameter int NUM_FEATURES = 16,
    parameter int FRAC_BITS    = 4,
    parameter int NUM_PIXELS   = 1024
) (
    input  logic clk,
    input  logic rst,
    bn_stream_ctrl_if.master bus
`ifdef BN_SAT_COUNT_EN
    ,
    output logic [15:0] sat_count
`endif
);
    localparam int AW = $clog2(NUM_FEATURES);
    localparam int CW = $clog2(NUM_FEATURES + 1);
    localparam int PW = $clog2(NUM_PIXELS + 1);

    bn_state_e                    state_q, state_d;
    logic [CW-1:0]                load_cnt_q, load_cnt_d;
    logic [AW-1:0]                chan_q, chan_d, cap_addr_s;
    logic [PW-1:0]                pix_q, pix_d;
    logic signed [DATA_WIDTH-1:0] w_q [NUM_FEATURES];
    logic signed [DATA_WIDTH-1:0] w_d [NUM_FEATURES];
    logic signed [DATA_WIDTH-1:0] b_q [NUM_FEATURES];
    logic signed [DATA_WIDTH-1:0] b_d [NUM_FEATURES];
    logic                         busy_q, busy_d, param_rd_q, param_rd_d;
    logic [AW-1:0]                param_addr_q, param_addr_d;
    logic                         start_ok_s, load_last_s, in_last_s, advance_s;
    logic                         s_ready_s, accept_s, xfer_last_s, done_s;
    logic                         out_valid_s, out_last_s, lane_sat_s;
    logic signed [DATA_WIDTH-1:0] out_data_s;
    logic [AW-1:0]                out_chan_s;

    // Handshake and event decode; start only counts when idle
    always_comb begin
        start_ok_s  = (state_q == IDLE) && bus.start;
        load_last_s = (load_cnt_q == CW'(NUM_FEATURES));
        in_last_s   = (chan_q == AW'(NUM_FEATURES - 1)) && (pix_q == PW'(NUM_PIXELS - 1));
        advance_s   = !out_valid_s || bus.m_ready;
        s_ready_s   = (state_q == RUN) && advance_s;
        accept_s    = s_ready_s && bus.s_valid;
        xfer_last_s = out_valid_s && bus.m_ready && out_last_s;
        cap_addr_s  = AW'(load_cnt_q - CW'(1));
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok_s)             state_d = LOAD;  else state_d = IDLE;
            LOAD:    if (load_last_s)            state_d = RUN;   else state_d = LOAD;
            RUN:     if (accept_s && in_last_s)  state_d = DRAIN; else state_d = RUN;
            DRAIN:   if (xfer_last_s)            state_d = IDLE;  else state_d = DRAIN;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output decode; read strobe and address are pre-computed from next values
    always_comb begin
        busy_d     = (state_d != IDLE);
        param_rd_d = (state_d == LOAD) && (load_cnt_d < CW'(NUM_FEATURES));
        if (param_rd_d) begin
            param_addr_d = load_cnt_d[AW-1:0];
        end else begin
            param_addr_d = {AW{1'b0}};
        end
        done_s = (state_q == DRAIN) && xfer_last_s;
    end

    // Counters and register file; memory data lags the strobe, hence cap_addr = cnt-1
    always_comb begin
        load_cnt_d = load_cnt_q;
        chan_d     = chan_q;
        pix_d      = pix_q;
        w_d        = w_q;
        b_d        = b_q;
        if (start_ok_s) begin
            load_cnt_d = {CW{1'b0}};
            chan_d     = {AW{1'b0}};
            pix_d      = {PW{1'b0}};
        end else if (state_q == LOAD) begin
            if (!load_last_s) begin
                load_cnt_d = load_cnt_q + CW'(1);
            end else begin
                load_cnt_d = load_cnt_q;
            end
            if (load_cnt_q != {CW{1'b0}}) begin
                w_d[cap_addr_s] = bus.param_weight;
                b_d[cap_addr_s] = bus.param_bias;
            end else begin
                w_d = w_q;
            end
        end else if (accept_s) begin
            if (chan_q == AW'(NUM_FEATURES - 1)) begin
                chan_d = {AW{1'b0}};
                pix_d  = pix_q + PW'(1);
            end else begin
                chan_d = chan_q + AW'(1);
            end
        end else begin
            chan_d = chan_q;
        end
    end

    // Datapath and registered-output flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_cnt_q   <= {CW{1'b0}};
            chan_q       <= {AW{1'b0}};
            pix_q        <= {PW{1'b0}};
            busy_q       <= 1'b0;
            param_rd_q   <= 1'b0;
            param_addr_q <= {AW{1'b0}};
            for (int i = 0; i < NUM_FEATURES; i++) begin
                w_q[i] <= {DATA_WIDTH{1'b0}};
                b_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            load_cnt_q   <= load_cnt_d;
            chan_q       <= chan_d;
            pix_q        <= pix_d;
            busy_q       <= busy_d;
            param_rd_q   <= param_rd_d;
            param_addr_q <= param_addr_d;
            w_q          <= w_d;
            b_q          <= b_d;
        end
    end

    bn_mac_lane #(
        .FRAC_BITS (FRAC_BITS),
        .AW        (AW)
    ) u_lane (
        .clk       (clk),
        .rst       (rst),
        .en        (advance_s),
        .in_valid  (accept_s),
        .in_data   (bus.s_data),
        .in_weight (w_q[chan_q]),
        .in_bias   (b_q[chan_q]),
        .in_chan   (chan_q),
        .in_last   (in_last_s),
        .out_valid (out_valid_s),
        .out_data  (out_data_s),
        .out_chan  (out_chan_s),
        .out_last  (out_last_s),
        .out_sat   (lane_sat_s)
    );

`ifdef BN_SAT_COUNT_EN
    logic [15:0] sat_count_q, sat_count_d;

    // Clamped-output counter, sticks at all ones
    always_comb begin
        if (start_ok_s) begin
            sat_count_d = 16'h0000;
        end else if (out_valid_s && bus.m_ready && lane_sat_s && (sat_count_q != 16'hFFFF)) begin
            sat_count_d = sat_count_q + 16'h0001;
        end else begin
            sat_count_d = sat_count_q;
        end
    end

    // Saturation counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_count_q <= 16'h0000;
        end else begin
            sat_count_q <= sat_count_d;
        end
    end

    assign sat_count = sat_count_q;
`else
    logic unused_sat_s;
    assign unused_sat_s = lane_sat_s;
`endif

    assign bus.busy       = busy_q;
    assign bus.done       = done_s;
    assign bus.param_rd   = param_rd_q;
    assign bus.param_addr = param_addr_q;
    assign bus.s_ready    = s_ready_s;
    assign bus.m_valid    = out_valid_s;
    assign bus.m_data     = out_data_s;
    assign bus.m_chan     = out_chan_s;
    assign bus.m_last     = out_last_s;

endmodule

// File: tb/tb_bn_stream_ctrl.sv
// Self-checking bench for bn_stream_ctrl (N=4, DW=8, FRAC=4, 2 pixels/frame)
// against a floor-division/clamp reference model.
module tb_bn_stream_ctrl;

    localparam int N   = 4;
    localparam int P   = 2;
    localparam int TOT = N * P;

    logic clk = 1'b0;
    logic rst;
    bn_stream_ctrl_if #(.AW(2)) bus ();
`ifdef BN_SAT_COUNT_EN
    logic [15:0] sat_count;
`endif

    logic signed [7:0] mem_w [N];
    logic signed [7:0] mem_b [N];
    int stim [TOT];
    int n_checks = 0;
    int n_pass   = 0;

    bn_stream_ctrl #(.NUM_FEATURES(N), .FRAC_BITS(4), .NUM_PIXELS(P)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef BN_SAT_COUNT_EN
        , .sat_count (sat_count)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous parameter memory: data valid the cycle after the strobe
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.param_weight <= 8'sd0;
            bus.param_bias   <= 8'sd0;
        end else if (bus.param_rd) begin
            bus.param_weight <= mem_w[bus.param_addr];
            bus.param_bias   <= mem_b[bus.param_addr];
        end
    end

    function automatic int floor16(int p);
        if (p >= 0) return p / 16;
        return -((-p + 15) / 16);
    endfunction

    function automatic int bn_ref(int x, int w, int b);
        int s;
        s = floor16(x * w) + b;
        if (s > 127) return 127;
        if (s < -128) return -128;
        return s;
    endfunction

    function automatic bit bn_sat(int x, int w, int b);
        int s;
        s = floor16(x * w) + b;
        return (s > 127) || (s < -128);
    endfunction

    task automatic rand_params();
        for (int i = 0; i < N; i++) begin
            mem_w[i] = 8'($urandom_range(0, 255));
            mem_b[i] = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic rand_stim();
        for (int i = 0; i < TOT; i++) stim[i] = int'($urandom_range(0, 255)) - 128;
    endtask

    task automatic idle_inputs();
        bus.start   = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'sd0;
        bus.m_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        n_checks++;
        if ({bus.busy, bus.done, bus.param_rd, bus.param_addr, bus.s_ready,
             bus.m_valid, bus.m_data, bus.m_chan, bus.m_last} !== 17'd0)
            $display("FAIL %s: outputs got %b required all zero", tag,
                     {bus.busy, bus.done, bus.param_rd, bus.param_addr, bus.s_ready,
                      bus.m_valid, bus.m_data, bus.m_chan, bus.m_last});
        else n_pass++;
    endtask

    // One frame from start pulse (cycle 0) to 3 cycles past done, checking as it goes
    task automatic drive_frame(input bit gaps, input int bp_at, input int bp_len, input bit ready_rand,
                               input int abort_at, input bit start_in_run, input bit start_on_done,
                               input bit chk_lat);
        int exp_d[$]; int exp_c[$]; bit exp_l[$];
        int n_in = 0, n_out = 0, cyc = 0, dones = 0, rd_cnt = 0, sat_exp = 0;
        int first_acc = -1, first_mv = -1, first_sr = -1, done_cyc = -1;
        bit prev_stall = 1'b0, prev_last = 1'b0;
        logic signed [7:0] prev_data = 8'sd0;
        logic [1:0] prev_chan = 2'd0;
        int ed, ec; bit el;
        while (cyc < 300) begin
            @(negedge clk);
            if (cyc == abort_at) return;
            bus.start   = (cyc == 0) || (start_in_run && cyc == 10);
            bus.s_valid = (n_in < TOT) && (!gaps || ($urandom_range(0, 3) != 0));
            bus.s_data  = (n_in < TOT) ? 8'(stim[n_in]) : 8'sd0;
            bus.m_ready = !(cyc >= bp_at && cyc < bp_at + bp_len) && (!ready_rand || ($urandom_range(0, 2) != 0));
            #1;
            if (cyc == 1) begin
                n_checks++;
                if (bus.busy !== 1'b1) $display("FAIL busy_in_load: got %b required 1", bus.busy);
                else n_pass++;
            end
            if (bus.param_rd === 1'b1) begin
                n_checks++;
                if (bus.param_addr !== 2'(rd_cnt)) $display("FAIL param_addr: got %0d required %0d", bus.param_addr, rd_cnt);
                else n_pass++;
                n_checks++;
                if (cyc !== rd_cnt + 1) $display("FAIL param_rd_cycle: got %0d required %0d", cyc, rd_cnt + 1);
                else n_pass++;
                rd_cnt++;
            end
            if (bus.s_ready === 1'b1 && first_sr < 0) begin
                first_sr = cyc;
                n_checks++;
                if (first_sr !== N + 2) $display("FAIL first_s_ready: got cycle %0d required %0d", first_sr, N + 2);
                else n_pass++;
            end
            if (prev_stall) begin
                n_checks++;
                if ({bus.m_valid, bus.m_data, bus.m_chan, bus.m_last} !== {1'b1, prev_data, prev_chan, prev_last})
                    $display("FAIL hold_stable: got %0d/%0d/%0d/%0d required 1/%0d/%0d/%0d", bus.m_valid,
                             bus.m_data, bus.m_chan, bus.m_last, prev_data, prev_chan, prev_last);
                else n_pass++;
            end
            if (bus.m_valid && !bus.m_ready) begin
                n_checks++;
                if (bus.s_ready !== 1'b0) $display("FAIL s_ready_bp: got %b required 0", bus.s_ready);
                else n_pass++;
            end
            if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
                if (first_mv < 0) first_mv = cyc;
                n_checks++;
                if (exp_d.size() == 0) begin
                    $display("FAIL extra_output: got data %0d required none", bus.m_data);
                end else begin
                    ed = exp_d.pop_front(); ec = exp_c.pop_front(); el = exp_l.pop_front();
                    if (int'(bus.m_data) !== ed || int'(bus.m_chan) !== ec || bus.m_last !== el)
                        $display("FAIL output[%0d]: got %0d ch%0d last%0d required %0d ch%0d last%0d", n_out,
                                 bus.m_data, bus.m_chan, bus.m_last, ed, ec, el);
                    else n_pass++;
                    n_checks++;
                    if (bus.done !== el) $display("FAIL done_on_last: got %b required %b", bus.done, el);
                    else n_pass++;
                end
                n_out++;
            end else begin
                n_checks++;
                if (bus.done !== 1'b0) $display("FAIL done_spurious: got %b required 0", bus.done);
                else n_pass++;
            end
            if (done_cyc >= 0) begin
                n_checks++;
                if ({bus.busy, bus.param_rd} !== 2'b00)
                    $display("FAIL after_done: busy/param_rd got %b%b required 00", bus.busy, bus.param_rd);
                else n_pass++;
            end
            if (bus.s_valid && bus.s_ready) begin
                exp_d.push_back(bn_ref(stim[n_in], int'(mem_w[n_in % N]), int'(mem_b[n_in % N])));
                exp_c.push_back(n_in % N);
                exp_l.push_back(n_in == TOT - 1);
                if (bn_sat(stim[n_in], int'(mem_w[n_in % N]), int'(mem_b[n_in % N]))) sat_exp++;
                if (first_acc < 0) first_acc = cyc;
                n_in++;
            end
            if (bus.done === 1'b1) begin
                dones++;
                done_cyc = cyc;
                if (start_on_done) bus.start = 1'b1;
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
            prev_chan  = bus.m_chan;
            prev_last  = bus.m_last;
            cyc++;
            if (done_cyc >= 0 && cyc > done_cyc + 3) break;
        end
        @(negedge clk);
        idle_inputs();
        n_checks++;
        if (done_cyc < 0) $display("FAIL frame_timeout: got no done in %0d cycles required done", cyc);
        else n_pass++;
        n_checks++;
        if (dones !== 1 || n_out !== TOT || exp_d.size() != 0)
            $display("FAIL frame_count: got dones %0d outputs %0d required 1 and %0d", dones, n_out, TOT);
        else n_pass++;
        n_checks++;
        if (rd_cnt !== N) $display("FAIL param_reads: got %0d required %0d", rd_cnt, N);
        else n_pass++;
        if (chk_lat) begin
            n_checks++;
            if (first_mv - first_acc !== 2) $display("FAIL latency: got %0d required 2", first_mv - first_acc);
            else n_pass++;
        end
`ifdef BN_SAT_COUNT_EN
        n_checks++;
        if (sat_count !== 16'(sat_exp)) $display("FAIL sat_count: got %0d required %0d", sat_count, sat_exp);
        else n_pass++;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
`ifdef BN_SAT_COUNT_EN
        n_checks++;
        if (sat_count !== 16'h0000) $display("FAIL reset_sat_count: got %0d required 0", sat_count);
        else n_pass++;
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_passthrough();
        for (int i = 0; i < N; i++) begin mem_w[i] = 8'sh10; mem_b[i] = 8'sd0; end
        rand_stim();
        stim[0] = 5; stim[1] = -7; stim[2] = 100; stim[3] = -128;
        drive_frame(1'b0, 1000, 0, 1'b0, -1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < N; i++) begin mem_w[i] = 8'sh20; mem_b[i] = 8'sd0; end
        stim[0] = 100; stim[1] = -100; stim[2] = 10; stim[3] = -10;
        stim[4] = 3;   stim[5] = -3;   stim[6] = 63; stim[7] = -64;
        drive_frame(1'b0, 1000, 0, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_bias_rounding();
        rand_params();
        rand_stim();
        mem_w[0] = 8'sh18; mem_b[0] = 8'sd3; stim[0] = -3;
        drive_frame(1'b0, 1000, 0, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        rand_params();
        rand_stim();
        drive_frame(1'b0, 10, 5, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_start_ignored();
        rand_params();
        rand_stim();
        drive_frame(1'b1, 1000, 0, 1'b0, -1, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            rand_params();
            rand_stim();
            drive_frame(1'b1, 1000, 0, 1'b1, -1, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 2; r++) begin
            rand_params();
            rand_stim();
            drive_frame(1'b0, 1000, 0, 1'b0, -1, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset_mid_run();
        rand_params();
        rand_stim();
        drive_frame(1'b0, 1000, 0, 1'b0, 12, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        idle_inputs();
        #1;
        check_all_zero("reset_mid_run");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rand_params();
        rand_stim();
        drive_frame(1'b0, 1000, 0, 1'b0, -1, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_saturation();
        test_bias_rounding();
        test_backpressure();
        test_start_ignored();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
